// File: rtl/load_scoreboard_hazard_unit_pkg.sv
// riscv_hazard_pkg: forwarding-select encodings and sizing helper shared by the hazard unit
package riscv_hazard_pkg;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_RSVD  = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/load_scoreboard_hazard_unit_if.sv
// load_scoreboard_hazard_unit_if: pipeline-side view of the hazard unit (core drives master, unit is slave)
interface load_scoreboard_hazard_unit_if
  import riscv_hazard_pkg::*;
#(
  parameter int REG_BITS    = 5,
  parameter int MAX_PENDING = 4,
  parameter int CNT_WIDTH   = 32
);
  logic [REG_BITS-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, id_regWrite, id_memRead;
  logic ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, wb_regWrite;
  logic load_issue, load_done, branch_taken, report;
  logic stall, flush_ifid, flush_idex;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [REG_BITS-1:0] load_done_rd;
  logic [clog2(MAX_PENDING):0] pending_count;
  logic overflow_err, underflow_err;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_cycles;
  modport master (
    output id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           id_uses_rs1, id_uses_rs2, id_regWrite, id_memRead,
           ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, wb_regWrite,
           load_issue, load_done, branch_taken, report,
    input  stall, flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel, load_done_rd,
           pending_count, overflow_err, underflow_err, stall_cycles, flush_cycles
  );
  modport slave (
    input  id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           id_uses_rs1, id_uses_rs2, id_regWrite, id_memRead,
           ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, wb_regWrite,
           load_issue, load_done, branch_taken, report,
    output stall, flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel, load_done_rd,
           pending_count, overflow_err, underflow_err, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/load_scoreboard_hazard_unit_tag_fifo.sv
// tag_fifo: in-order destination-tag FIFO with a per-value content-match vector over valid entries
module tag_fifo
  import riscv_hazard_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count,
  output logic [2**WIDTH-1:0]      match
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = mem[rd_ptr];
  // pointers, occupancy and valid flags; a same-cycle pop and push on one slot leaves it valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // tag storage needs no reset because valid masks every read
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // decode every valid entry into a one-hot-per-register pending vector
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) if (valid[i]) match[mem[i]] = 1'b1;
  end
endmodule

// File: rtl/load_scoreboard_hazard_unit.sv
// load_scoreboard_hazard_unit: load scoreboard, ID stall, EX forwarding, flushes and perf counters
module load_scoreboard_hazard_unit
  import riscv_hazard_pkg::*;
#(
  parameter int CORE        = 0,
  parameter int REG_BITS    = 5,
  parameter int MAX_PENDING = 4,
  parameter int CNT_WIDTH   = 32
) (
  input logic clock,
  input logic reset,
  load_scoreboard_hazard_unit_if.slave bus
);
  localparam int PW = clog2(MAX_PENDING) + 1;
  logic [2**REG_BITS-1:0] match, busy;
  logic [REG_BITS-1:0] head;
  logic full, empty, raw1, raw2, waw, cap, stall;
  logic [PW-1:0] count;
  logic [PW:0] inflight;
  function automatic logic [1:0] fwd(input logic [REG_BITS-1:0] rs, input logic mw, input logic mr,
                                     input logic [REG_BITS-1:0] md, input logic ww,
                                     input logic [REG_BITS-1:0] wd);
    return (rs == '0) ? FWD_RF : (mw & ~mr & md == rs) ? FWD_EXMEM : (ww & wd == rs) ? FWD_MEMWB : FWD_RF;
  endfunction
  tag_fifo #(.WIDTH(REG_BITS), .DEPTH(MAX_PENDING)) u_fifo (
    .clock(clock), .reset(reset), .push(bus.load_issue), .pop(bus.load_done), .din(bus.mem_rd),
    .head(head), .full(full), .empty(empty), .count(count), .match(match)
  );
  // a register is busy while a load to it is queued, sitting in EX, or sitting in MEM; x0 never is
  always_comb begin
    busy = match;
    if (bus.ex_memRead) busy[bus.ex_rd] = 1'b1;
    if (bus.mem_memRead) busy[bus.mem_rd] = 1'b1;
    busy[0] = 1'b0;
  end
  assign raw1 = bus.id_uses_rs1 & busy[bus.id_rs1];
  assign raw2 = bus.id_uses_rs2 & busy[bus.id_rs2];
  assign waw = bus.id_regWrite & busy[bus.id_rd];
  assign inflight = {1'b0, count} + (PW+1)'(bus.ex_memRead) + (PW+1)'(bus.mem_memRead);
  assign cap = bus.id_memRead & (inflight >= (PW+1)'(MAX_PENDING));
  assign stall = (raw1 | raw2 | waw | cap) & ~bus.branch_taken;
  assign bus.stall = stall;
  assign bus.flush_ifid = bus.branch_taken;
  assign bus.flush_idex = bus.branch_taken | stall;
  assign bus.fwd_a_sel = fwd(bus.ex_rs1, bus.mem_regWrite, bus.mem_memRead, bus.mem_rd, bus.wb_regWrite, bus.wb_rd);
  assign bus.fwd_b_sel = fwd(bus.ex_rs2, bus.mem_regWrite, bus.mem_memRead, bus.mem_rd, bus.wb_regWrite, bus.wb_rd);
  assign bus.load_done_rd = empty ? '0 : head;
  assign bus.pending_count = count;
  // sticky protocol errors and saturating stall/flush counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.overflow_err <= 1'b0;
      bus.underflow_err <= 1'b0;
      bus.stall_cycles <= '0;
      bus.flush_cycles <= '0;
    end else begin
      if (bus.load_issue & full & ~bus.load_done) bus.overflow_err <= 1'b1;
      if (bus.load_done & empty) bus.underflow_err <= 1'b1;
      if (stall & ~&bus.stall_cycles) bus.stall_cycles <= bus.stall_cycles + 1'b1;
      if (bus.branch_taken & ~&bus.flush_cycles) bus.flush_cycles <= bus.flush_cycles + 1'b1;
    end
  end
`ifndef SYNTHESIS
  // performance report for simulation logs
  always @(posedge clock) begin
    if (reset && bus.report)
      $display("core %0d: stall_cycles=%0d flush_cycles=%0d pending=%0d",
               CORE, bus.stall_cycles, bus.flush_cycles, bus.pending_count);
  end
`endif
endmodule
